// File: rtl/trigger_capture_pkg.sv
// trigger_capture_pkg: shared widths, event record type and fill-level sizing for the trigger capture unit
package trigger_capture_pkg;
  localparam int TS_WIDTH_DEF   = 32;
  localparam int SEL_WIDTH_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DROP_WIDTH_DEF = 16;
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int FILL_WIDTH_DEF = fill_width(FIFO_DEPTH_DEF);
  typedef struct packed {
    logic [SEL_WIDTH_DEF-1:0] sel;
    logic [TS_WIDTH_DEF-1:0]  ts;
  } trig_event_t;
endpackage

// File: rtl/trig_event_fifo.sv
// trig_event_fifo: show-ahead event FIFO; a push into a full FIFO succeeds when a pop happens on the same edge
module trig_event_fifo
  import trigger_capture_pkg::*;
#(
  parameter type T = trig_event_t,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = fill_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_en,
  input  T              wr_data,
  input  logic          rd_ack,
  output T              rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign pop     = rd_ack & ~empty;
  assign push    = wr_en & (~full | pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/trigger_capture_unit.sv
// trigger_capture_unit: timestamps accepted trigger rising edges with the scenario tag, measures trigger
// period and keeps event statistics; records reach the FIFO one cycle after the edge is seen
module trigger_capture_unit
  import trigger_capture_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF,
  localparam int FW = fill_width(FIFO_DEPTH)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          capture_en,
  input  logic                          clear,
  input  logic                          output_trigger,
  input  logic [SEL_WIDTH-1:0]          scen_sel,
  output logic                          rd_valid,
  output logic [SEL_WIDTH+TS_WIDTH-1:0] rd_data,
  input  logic                          rd_ack,
  output logic [FW-1:0]                 fill_level,
  output logic [TS_WIDTH-1:0]           last_period,
  output logic                          period_valid,
  output logic [31:0]                   event_count,
  output logic [DROP_WIDTH-1:0]         dropped_count,
  output logic                          overflow
);
  logic [TS_WIDTH-1:0] ts, prev_ts;
  logic [SEL_WIDTH+TS_WIDTH-1:0] pend_rec;
  logic trigger_prev, pend, have_prev, full, empty, edge_hit, drop;
  assign edge_hit = output_trigger & ~trigger_prev & capture_en;
  assign drop     = pend & full & ~(rd_ack & ~empty);
  assign rd_valid = ~empty;
  trig_event_fifo #(
    .T(logic [SEL_WIDTH+TS_WIDTH-1:0]),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .flush(clear),
    .wr_en(pend & ~clear),
    .wr_data(pend_rec),
    .rd_ack(rd_ack & ~clear),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(fill_level)
  );
  // trigger_prev starts high so a trigger already asserted at reset release is not an edge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      trigger_prev  <= 1'b1;
      ts            <= '0;
      prev_ts       <= '0;
      pend          <= 1'b0;
      pend_rec      <= '0;
      have_prev     <= 1'b0;
      last_period   <= '0;
      period_valid  <= 1'b0;
      event_count   <= '0;
      dropped_count <= '0;
      overflow      <= 1'b0;
    end else begin
      trigger_prev <= output_trigger;
      if (clear) begin
        ts            <= '0;
        prev_ts       <= '0;
        pend          <= 1'b0;
        have_prev     <= 1'b0;
        last_period   <= '0;
        period_valid  <= 1'b0;
        event_count   <= '0;
        dropped_count <= '0;
        overflow      <= 1'b0;
      end else begin
        ts       <= ts + 1'b1;
        pend     <= edge_hit;
        pend_rec <= {scen_sel, ts};
        if (pend) begin
          event_count <= event_count + 32'd1;
          prev_ts     <= pend_rec[TS_WIDTH-1:0];
          have_prev   <= 1'b1;
          if (have_prev) begin
            last_period  <= pend_rec[TS_WIDTH-1:0] - prev_ts;
            period_valid <= 1'b1;
          end
        end
        if (drop) begin
          dropped_count <= (dropped_count == '1) ? dropped_count : dropped_count + 1'b1;
          overflow      <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_trigger_capture_unit.sv
// tb_trigger_capture_unit: randomized and directed stimulus, queue-based reference model and negedge monitor
module tb_trigger_capture_unit;
  localparam int DEPTH = 16;
  logic clock = 1'b0, reset_n = 1'b0, capture_en = 1'b0, clear = 1'b0, output_trigger = 1'b0, rd_ack = 1'b0;
  logic [7:0] scen_sel = '0;
  logic rd_valid, period_valid, overflow;
  logic [39:0] rd_data;
  logic [4:0] fill_level;
  logic [31:0] last_period, event_count;
  logic [15:0] dropped_count;
  int n_tests = 0, n_fail = 0;

  trigger_capture_unit dut (
    .clock(clock), .reset_n(reset_n), .capture_en(capture_en), .clear(clear),
    .output_trigger(output_trigger), .scen_sel(scen_sel), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ack(rd_ack), .fill_level(fill_level), .last_period(last_period),
    .period_valid(period_valid), .event_count(event_count), .dropped_count(dropped_count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered records, accepted timestamps and statistics
  logic [39:0] q[$];
  logic [31:0] acc[$];
  logic [31:0] m_ts, m_ev, m_last;
  logic [15:0] m_drop;
  logic [39:0] m_rec;
  bit m_prev, m_pend, m_ovf;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete(); acc.delete();
      m_ts = 0; m_ev = 0; m_last = 0; m_drop = 0; m_ovf = 0; m_prev = 1; m_pend = 0; m_rec = 0;
    end else if (clear) begin
      q.delete(); acc.delete();
      m_ts = 0; m_ev = 0; m_last = 0; m_drop = 0; m_ovf = 0; m_pend = 0;
      m_prev = output_trigger;
    end else begin
      if (rd_ack && q.size() > 0) void'(q.pop_front());
      if (m_pend) begin
        m_ev++;
        acc.push_back(m_rec[31:0]);
        if (acc.size() > 2) void'(acc.pop_front());
        if (acc.size() == 2) m_last = acc[1] - acc[0];
        if (q.size() < DEPTH) q.push_back(m_rec);
        else begin
          if (m_drop != 16'hffff) m_drop++;
          m_ovf = 1;
        end
      end
      m_pend = output_trigger && !m_prev && capture_en;
      m_rec = {scen_sel, m_ts};
      m_prev = output_trigger;
      m_ts++;
    end
  end

  // Monitor: compares everything the DUT presents against the model
  always @(negedge clock) begin
    if (reset_n) begin
      check("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
      check("rd_data", 64'(rd_data), q.size() != 0 ? 64'(q[0]) : 64'd0);
      check("fill_level", 64'(fill_level), 64'(q.size()));
      check("event_count", 64'(event_count), 64'(m_ev));
      check("dropped_count", 64'(dropped_count), 64'(m_drop));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("period_valid", 64'(period_valid), 64'(acc.size() == 2));
      check("last_period", 64'(last_period), 64'(m_last));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic pulse();
    output_trigger = 1'b1;
    step();
    output_trigger = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    output_trigger = 1'b1;
    capture_en = 1'b1;
    step(3);
    reset_n = 1'b1;
    step(5);
    check("held_high_events", 64'(event_count), 64'd0);
    check("held_high_valid", 64'(rd_valid), 64'd0);
    output_trigger = 1'b0;
    step();
    pulse();
    check("rearm_events", 64'(event_count), 64'd1);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;

    do_clear();
    for (int i = 0; i < 8; i++) begin
      scen_sel = 8'(i / 2);
      pulse();
      step(998);
    end
    check("scen_fill", 64'(fill_level), 64'd8);
    check("scen_period", 64'(last_period), 64'd1000);
    check("scen_pvalid", 64'(period_valid), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("scen_tag", 64'(rd_data[39:32]), 64'(i / 2));
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
    end
    check("scen_drained", 64'(rd_valid), 64'd0);

    do_clear();
    capture_en = 1'b0;
    repeat (5) pulse();
    check("disarmed_events", 64'(event_count), 64'd0);
    check("disarmed_valid", 64'(rd_valid), 64'd0);
    capture_en = 1'b1;
    pulse();
    check("armed_fill", 64'(fill_level), 64'd1);

    do_clear();
    repeat (20) pulse();
    check("ovf_fill", 64'(fill_level), 64'd16);
    check("ovf_dropped", 64'(dropped_count), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_events", 64'(event_count), 64'd20);
    output_trigger = 1'b1;
    step();
    output_trigger = 1'b0;
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("collide_fill", 64'(fill_level), 64'd16);
    check("collide_dropped", 64'(dropped_count), 64'd4);
    rd_ack = 1'b1;
    step(17);
    rd_ack = 1'b0;
    check("drained_valid", 64'(rd_valid), 64'd0);
    check("drained_ovf", 64'(overflow), 64'd1);

    output_trigger = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    output_trigger = 1'b0;
    check("clear_fill", 64'(fill_level), 64'd0);
    check("clear_events", 64'(event_count), 64'd0);
    check("clear_ovf", 64'(overflow), 64'd0);
    step(9);
    pulse();
    check("post_clear_fill", 64'(fill_level), 64'd1);
    check("post_clear_ts_near_10", 64'(rd_data[31:0] >= 8 && rd_data[31:0] <= 12), 64'd1);
    check("post_clear_pvalid", 64'(period_valid), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      output_trigger = $urandom_range(0, 2) == 0;
      capture_en = $urandom_range(0, 9) != 0;
      rd_ack = $urandom_range(0, 3) == 0;
      clear = $urandom_range(0, 199) == 0;
      scen_sel = 8'($urandom);
      step();
    end
    clear = 1'b0;
    rd_ack = 1'b0;
    capture_en = 1'b1;
    repeat (3) pulse();
    output_trigger = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(rd_valid), 64'd0);
    check("async_rst_data", 64'(rd_data), 64'd0);
    check("async_rst_fill", 64'(fill_level), 64'd0);
    check("async_rst_events", 64'(event_count), 64'd0);
    check("async_rst_period", 64'(last_period), 64'd0);
    check("async_rst_pvalid", 64'(period_valid), 64'd0);
    check("async_rst_dropped", 64'(dropped_count), 64'd0);
    check("async_rst_ovf", 64'(overflow), 64'd0);
    step(2);
    reset_n = 1'b1;
    step(4);
    check("rst_held_high_events", 64'(event_count), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trigger_capture_unit.md
Name: trigger_capture_unit

Overview:
- Receiving end of the scenario multiplexer's trigger output.
- Watches `output_trigger` and timestamps every rising edge, tagging each one with the `scen_sel` value active at that moment.
- Also measures the interval between consecutive triggers.
- Buffers event records in a small FIFO that software drains through a show-ahead read handshake; it is the measurement/readback path used to verify scenario timing in-system.

Parameters:
- TS_WIDTH, 32: free-running timestamp counter width (clock cycles).
- SEL_WIDTH, 8: width of scenario select tag stored per event.
- FIFO_DEPTH, 16: event buffer depth; power of two, ≥2.
- DROP_WIDTH, 16: width of saturating dropped-event counter.

Ports:
- clock  in  1  system clock (same domain as scenario_multiplexer).
- reset_n  in  1  asynchronous active-low reset.
- capture_en  in  1  arm capture; edges ignored when low.
- clear  in  1  synchronous flush: FIFO, counters, timestamp, period, overflow.
- output_trigger  in  1  trigger from scenario_multiplexer, synchronous to clock.
- scen_sel  in  SEL_WIDTH  current scenario select, sampled with each edge.
- rd_valid  out  1  FIFO non-empty; rd_data holds oldest event.
- rd_data  out  SEL_WIDTH+TS_WIDTH  {sel, timestamp} of oldest event.
- rd_ack  in  1  pop oldest event when rd_valid high.
- fill_level  out  $clog2(FIFO_DEPTH)+1  number of stored events.
- last_period  out  TS_WIDTH  cycles between the two most recent accepted edges.
- period_valid  out  1  at least two edges accepted since reset/clear.
- event_count  out  32  accepted edges, wraps modulo 2^32.
- dropped_count  out  DROP_WIDTH  edges lost to full FIFO, saturating.
- overflow  out  1  sticky: any edge dropped since reset/clear.

Behaviour:
- Reset (reset_n low, async):
  - All outputs 0, FIFO empty, timestamp 0.
  - Internal trigger_prev register set to 1, so a trigger already high at release is not counted.
- Timestamp counter:
  - Increments every clock, wraps modulo 2^TS_WIDTH.
  - clear forces it to 0 on that edge; it counts from 0 afterwards.
- Edge detection:
  - An edge occurs at clock edge N when output_trigger=1 and trigger_prev=0.
  - trigger_prev updates every cycle regardless of capture_en.
  - An edge is accepted only if capture_en=1 in the same cycle.
- Accepted edge at edge N:
  - The record is {scen_sel, ts} using the values present in that cycle.
  - It is written at edge N+1; rd_valid is high after edge N+1 (1-cycle latency).
  - event_count increments at edge N+1.
  - last_period = ts − previous_ts (modulo 2^TS_WIDTH), updated at N+1.
  - period_valid sets on the second accepted edge.
- FIFO full at write time:
  - Record discarded, dropped_count +1 (saturates at all-ones), overflow set.
  - event_count and last_period still update.
- Simultaneous write and rd_ack while full: pop and push both take effect; no drop.
- Simultaneous write and rd_ack while holding one entry: FIFO stays non-empty, rd_data advances to the new record.
- rd_ack with rd_valid=0 is ignored and has no effect.
- clear:
  - Priority over edge capture and rd_ack in the same cycle.
  - Pending write is discarded; all counters, period_valid, overflow and FIFO go to 0/empty.
  - trigger_prev keeps tracking the input.
- Trigger held high produces one event only. Back-to-back edges 2 cycles apart are all captured.
- fill_level and rd_valid are registered from the FIFO pointers and track the same edge as the write/pop.

Decomposition:
- Package `trigger_capture_pkg` holds:
  - SEL_WIDTH/TS_WIDTH defaults.
  - typedef struct packed trig_event_t {sel; ts}.
  - Localparam for fill_level width.
- Sub-module `trig_event_fifo`: synchronous show-ahead FIFO of trig_event_t with wr_en, rd_ack, full, empty and count outputs, and synchronous flush.
- Top level holds edge detection, timestamp counter, period and statistics logic.

Test Plan:
- Reset release with trigger already high, capture_en=1 → event_count stays 0 and rd_valid stays 0 until the trigger falls and rises again.
- scen_sel=0,1,2,3 each held 10 us (2000 cycles), one trigger pulse per scenario every 1000 cycles → 8 records, sel tags 0,0,1,1,2,2,3,3; last_period=1000; period_valid=1.
- capture_en=0 during 5 pulses → FIFO empty, event_count=0; raise capture_en → next pulse yields record with fill_level=1.
- 20 pulses, no rd_ack, FIFO_DEPTH=16 → fill_level=16, dropped_count=4, overflow=1, event_count=20; drain 16 records with rd_ack → rd_valid=0, overflow stays 1.
- FIFO full, with the edge write and rd_ack in the same cycle → fill_level stays 16, dropped_count unchanged.
- Assert clear in the same cycle as an edge → all outputs 0, FIFO empty; next pulse 10 cycles later has ts≈10 and period_valid=0.
- Assert reset_n low mid-stream → outputs 0 immediately without a clock edge.
